// File: rtl/sys_trap_pkg.sv
// Shared constants for the machine-mode trap-entry controller: CSR addresses,
// interrupt cause codes, CSR bit positions and FSM state encoding.
package sys_trap_pkg;

  localparam logic [11:0] CSR_MSTATUS     = 12'h300;
  localparam logic [11:0] CSR_MIE         = 12'h304;
  localparam logic [11:0] CSR_MIP         = 12'h344;
  localparam logic [11:0] CSR_MTIMECMP_LO = 12'h7C0;
  localparam logic [11:0] CSR_MTIMECMP_HI = 12'h7C1;

  localparam logic [31:0] CAUSE_EXT   = 32'h8000_000B;
  localparam logic [31:0] CAUSE_TIMER = 32'h8000_0007;

  localparam int MIE_BIT  = 3;
  localparam int MPIE_BIT = 7;
  localparam int MTIE_BIT = 7;
  localparam int MEIE_BIT = 11;
  localparam int MTIP_BIT = 7;
  localparam int MEIP_BIT = 11;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_REQ  = 2'd1;
  localparam state_t ST_JUMP = 2'd2;

endpackage

// File: rtl/sys_trap_sync_bit.sv
// Multi-flop synchronizer for a single asynchronous level; output is the
// input delayed by STAGES clock edges.
module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/sys_trap.sv
// Machine-mode interrupt controller: owns mstatus.MIE/MPIE, mie, mip and mtimecmp,
// and drives the drain handshake and trap-entry redirect toward fetch/CSR unit.
module sys_trap
  import sys_trap_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            irq_ext,
  input  logic [63:0]     mtime,
  input  logic [XLEN-1:0] mtvec,
  input  logic            csr_wr_vld,
  input  logic [11:0]     csr_wr_addr,
  input  logic [XLEN-1:0] csr_wr_data,
  input  logic [11:0]     csr_rd_addr,
  output logic [XLEN-1:0] csr_rd_data,
  input  logic            mret_vld,
  output logic            trap_req,
  input  logic            trap_ack,
  input  logic [XLEN-1:0] retire_pc,
  output logic            jump_vld,
  output logic [XLEN-1:0] jump_pc,
  output logic            mepc_wr_vld,
  output logic [XLEN-1:0] mepc_wr_data,
  output logic [XLEN-1:0] mcause_wr_data
);

  state_t          state_q, state_d;
  logic [31:0]     cause_q, cause_d;
  logic [XLEN-1:0] epc_q, epc_d;
  logic            mstatus_mie_q, mstatus_mie_d;
  logic            mstatus_mpie_q, mstatus_mpie_d;
  logic            mie_mtie_q, mie_meie_q;
  logic [63:0]     mtimecmp_q;
  logic            mtip_q;
  logic            meip;
  logic            ext_hit, tmr_hit, take;

  sync_bit #(
    .STAGES (SYNC_STAGES)
  ) u_sync_irq (
    .clk (clk),
    .rst (rst),
    .d_i (irq_ext),
    .q_o (meip)
  );

  assign ext_hit = mie_meie_q & meip;
  assign tmr_hit = mie_mtie_q & mtip_q;
  // An mret in this cycle defers the decision until the restored MIE is visible.
  assign take    = mstatus_mie_q & (ext_hit | tmr_hit) & ~mret_vld;

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    epc_d   = epc_q;
    case (state_q)
      ST_IDLE: begin
        if (take) begin
          cause_d = ext_hit ? CAUSE_EXT : CAUSE_TIMER;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (trap_ack) begin
          epc_d   = retire_pc;
          state_d = ST_JUMP;
        end
      end
      ST_JUMP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Priority: trap entry, then mret, then a software write.
  always_comb begin
    mstatus_mie_d  = mstatus_mie_q;
    mstatus_mpie_d = mstatus_mpie_q;
    if (state_q == ST_JUMP) begin
      mstatus_mpie_d = mstatus_mie_q;
      mstatus_mie_d  = 1'b0;
    end else if (mret_vld) begin
      mstatus_mie_d  = mstatus_mpie_q;
      mstatus_mpie_d = 1'b1;
    end else if (csr_wr_vld && csr_wr_addr == CSR_MSTATUS) begin
      mstatus_mie_d  = csr_wr_data[MIE_BIT];
      mstatus_mpie_d = csr_wr_data[MPIE_BIT];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= ST_IDLE;
      cause_q        <= '0;
      epc_q          <= '0;
      mstatus_mie_q  <= 1'b0;
      mstatus_mpie_q <= 1'b0;
      mie_mtie_q     <= 1'b0;
      mie_meie_q     <= 1'b0;
      mtimecmp_q     <= '1;
      mtip_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      cause_q        <= cause_d;
      epc_q          <= epc_d;
      mstatus_mie_q  <= mstatus_mie_d;
      mstatus_mpie_q <= mstatus_mpie_d;
      mtip_q         <= (mtime >= mtimecmp_q);
      if (csr_wr_vld) begin
        case (csr_wr_addr)
          CSR_MIE: begin
            mie_mtie_q <= csr_wr_data[MTIE_BIT];
            mie_meie_q <= csr_wr_data[MEIE_BIT];
          end
          CSR_MTIMECMP_LO: mtimecmp_q[31:0]  <= csr_wr_data[31:0];
          CSR_MTIMECMP_HI: mtimecmp_q[63:32] <= csr_wr_data[31:0];
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    csr_rd_data = '0;
    case (csr_rd_addr)
      CSR_MSTATUS: begin
        csr_rd_data[MIE_BIT]  = mstatus_mie_q;
        csr_rd_data[MPIE_BIT] = mstatus_mpie_q;
      end
      CSR_MIE: begin
        csr_rd_data[MTIE_BIT] = mie_mtie_q;
        csr_rd_data[MEIE_BIT] = mie_meie_q;
      end
      CSR_MIP: begin
        csr_rd_data[MTIP_BIT] = mtip_q;
        csr_rd_data[MEIP_BIT] = meip;
      end
      CSR_MTIMECMP_LO: csr_rd_data = XLEN'(mtimecmp_q[31:0]);
      CSR_MTIMECMP_HI: csr_rd_data = XLEN'(mtimecmp_q[63:32]);
      default: csr_rd_data = '0;
    endcase
  end

  assign trap_req       = (state_q == ST_REQ);
  assign jump_vld       = (state_q == ST_JUMP);
  assign mepc_wr_vld    = jump_vld;
  assign jump_pc        = jump_vld ? (mtvec & ~XLEN'(3)) : '0;
  assign mepc_wr_data   = jump_vld ? (epc_q & ~XLEN'(3)) : '0;
  assign mcause_wr_data = jump_vld ? XLEN'(cause_q) : '0;

endmodule

// File: tb/tb_sys_trap.sv
// Directed and randomized checks of sys_trap against a trap-lifecycle model
// that tracks pending/firing traps and CSR contents.
module tb_sys_trap;

  localparam int S = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        irq_ext;
  logic [63:0] mtime;
  logic [31:0] mtvec;
  logic        csr_wr_vld;
  logic [11:0] csr_wr_addr;
  logic [31:0] csr_wr_data;
  logic [11:0] csr_rd_addr;
  logic [31:0] csr_rd_data;
  logic        mret_vld;
  logic        trap_req;
  logic        trap_ack;
  logic [31:0] retire_pc;
  logic        jump_vld;
  logic [31:0] jump_pc;
  logic        mepc_wr_vld;
  logic [31:0] mepc_wr_data;
  logic [31:0] mcause_wr_data;

  int checks = 0;
  int errors = 0;

  sys_trap #(.XLEN(32), .SYNC_STAGES(S)) dut (
    .clk(clk), .rst(rst), .irq_ext(irq_ext), .mtime(mtime), .mtvec(mtvec),
    .csr_wr_vld(csr_wr_vld), .csr_wr_addr(csr_wr_addr), .csr_wr_data(csr_wr_data),
    .csr_rd_addr(csr_rd_addr), .csr_rd_data(csr_rd_data), .mret_vld(mret_vld),
    .trap_req(trap_req), .trap_ack(trap_ack), .retire_pc(retire_pc),
    .jump_vld(jump_vld), .jump_pc(jump_pc), .mepc_wr_vld(mepc_wr_vld),
    .mepc_wr_data(mepc_wr_data), .mcause_wr_data(mcause_wr_data)
  );

  always #5 clk = ~clk;

  // Reference model: a trap is either outstanding (waiting for ack) or firing.
  bit          m_pending, m_firing;
  bit          m_mie, m_mpie, m_mtie, m_meie, m_mtip;
  bit [63:0]   m_cmp;
  bit [31:0]   m_cause, m_epc;
  bit          hist[$];   // irq_ext samples, oldest first; oldest is what MEIP shows

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pending = 0; m_firing = 0; m_mie = 0; m_mpie = 0; m_mtie = 0; m_meie = 0;
    m_mtip = 0; m_cmp = '1; m_cause = 0; m_epc = 0;
    hist.delete();
    for (int i = 0; i < S; i++) hist.push_back(1'b0);
  endtask

  function automatic logic [31:0] m_read(input logic [11:0] a);
    case (a)
      12'h300: return (32'(m_mpie) << 7) | (32'(m_mie) << 3);
      12'h304: return (32'(m_meie) << 11) | (32'(m_mtie) << 7);
      12'h344: return (32'(hist[0]) << 11) | (32'(m_mtip) << 7);
      12'h7C0: return m_cmp[31:0];
      12'h7C1: return m_cmp[63:32];
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_compare();
    check("trap_req", trap_req, m_pending);
    check("jump_vld", jump_vld, m_firing);
    check("mepc_wr_vld", mepc_wr_vld, m_firing);
    check("jump_pc", jump_pc, m_firing ? (mtvec & 32'hFFFF_FFFC) : 32'h0);
    check("mepc_wr_data", mepc_wr_data, m_firing ? (m_epc & 32'hFFFF_FFFC) : 32'h0);
    check("mcause_wr_data", mcause_wr_data, m_firing ? m_cause : 32'h0);
    check("csr_rd_data", csr_rd_data, m_read(csr_rd_addr));
  endtask

  task automatic model_advance();
    bit meip, ext, tmr, take;
    meip = hist[0];
    ext  = m_meie && meip;
    tmr  = m_mtie && m_mtip;
    take = !m_pending && !m_firing && !mret_vld && m_mie && (ext || tmr);
    if (m_firing) begin
      m_firing = 0;
      m_mpie   = m_mie;
      m_mie    = 0;
    end else begin
      if (m_pending && trap_ack) begin
        m_pending = 0; m_firing = 1; m_epc = retire_pc;
      end else if (take) begin
        m_pending = 1; m_cause = ext ? 32'h8000_000B : 32'h8000_0007;
      end
      if (mret_vld) begin
        m_mie = m_mpie; m_mpie = 1;
      end else if (csr_wr_vld && csr_wr_addr == 12'h300) begin
        m_mie = csr_wr_data[3]; m_mpie = csr_wr_data[7];
      end
    end
    if (csr_wr_vld && csr_wr_addr == 12'h304) begin
      m_mtie = csr_wr_data[7]; m_meie = csr_wr_data[11];
    end
    m_mtip = (mtime >= m_cmp);
    if (csr_wr_vld && csr_wr_addr == 12'h7C0) m_cmp[31:0]  = csr_wr_data;
    if (csr_wr_vld && csr_wr_addr == 12'h7C1) m_cmp[63:32] = csr_wr_data;
    hist.push_back(irq_ext);
    void'(hist.pop_front());
  endtask

  // Compare the current cycle, step the model across the coming edge, move to the next negedge.
  task automatic tick();
    #1;
    if (!rst) model_reset();
    model_compare();
    if (rst) model_advance();
    @(negedge clk);
  endtask

  task automatic csr_write(input logic [11:0] a, input logic [31:0] d);
    csr_wr_vld = 1; csr_wr_addr = a; csr_wr_data = d;
    tick();
    csr_wr_vld = 0;
  endtask

  task automatic wait_req(input int limit);
    int n = 0;
    while (trap_req !== 1'b1 && n < limit) begin
      tick();
      n++;
    end
    check("wait_req", trap_req, 1'b1);
  endtask

  initial begin
    rst = 0; irq_ext = 0; mtime = 0; mtvec = 32'h80; csr_wr_vld = 0; csr_wr_addr = 0;
    csr_wr_data = 0; csr_rd_addr = 12'h300; mret_vld = 0; trap_ack = 0; retire_pc = 0;
    model_reset();
    @(negedge clk);
    tick(); tick();
    check("rst_trap_req", trap_req, 1'b0);
    check("rst_jump_vld", jump_vld, 1'b0);
    check("rst_mstatus", csr_rd_data, 32'h0);
    csr_rd_addr = 12'h7C0; #1;
    check("rst_mtimecmp_lo", csr_rd_data, 32'hFFFF_FFFF);
    rst = 1;
    @(negedge clk);

    // External interrupt entry
    csr_write(12'h304, 32'h800);
    csr_write(12'h300, 32'h8);
    csr_rd_addr = 12'h344; irq_ext = 1;
    tick(); check("ext_req_edge0", trap_req, 1'b0);
    tick(); check("ext_req_edge1", trap_req, 1'b0); check("ext_mip", csr_rd_data, 32'h800);
    tick(); check("ext_req_edge2", trap_req, 1'b1);
    trap_ack = 1; retire_pc = 32'h104; mtvec = 32'h80;
    tick(); trap_ack = 0;
    check("ext_jump_vld", jump_vld, 1'b1);
    check("ext_jump_pc", jump_pc, 32'h80);
    check("ext_mepc", mepc_wr_data, 32'h104);
    check("ext_mcause", mcause_wr_data, 32'h8000_000B);
    csr_rd_addr = 12'h300;
    tick(); check("ext_jump_once", jump_vld, 1'b0); check("ext_mstatus", csr_rd_data, 32'h80);

    // Timer interrupt entry
    irq_ext = 0;
    csr_write(12'h7C0, 32'h10);
    csr_write(12'h7C1, 32'h1);
    mret_vld = 1; tick(); mret_vld = 0;
    csr_write(12'h304, 32'h80);
    csr_rd_addr = 12'h344; mtime = 64'h0000_0001_0000_000F;
    tick(); check("tmr_mip_below", csr_rd_data, 32'h0);
    mtime = 64'h0000_0001_0000_0010;
    tick(); check("tmr_mip_hit", csr_rd_data, 32'h80); check("tmr_req_early", trap_req, 1'b0);
    tick(); check("tmr_req", trap_req, 1'b1);
    trap_ack = 1; retire_pc = 32'h203; mtvec = 32'h101;
    tick(); trap_ack = 0;
    check("tmr_mcause", mcause_wr_data, 32'h8000_0007);
    check("tmr_mepc_align", mepc_wr_data, 32'h200);
    check("tmr_jump_align", jump_pc, 32'h100);
    csr_write(12'h7C0, 32'hFFFF_FFFF);
    csr_write(12'h7C1, 32'hFFFF_FFFF);
    tick(); check("tmr_mip_clear", csr_rd_data, 32'h0);

    // Both pending: masked, then external wins, then timer follows after mret
    csr_write(12'h304, 32'h880);
    irq_ext = 1;
    csr_write(12'h7C0, 32'h0);
    csr_write(12'h7C1, 32'h0);
    tick(); tick();
    check("both_masked_req", trap_req, 1'b0);
    check("both_mip", csr_rd_data, 32'h880);
    csr_write(12'h300, 32'h8);
    check("both_req_delay", trap_req, 1'b0);
    tick(); check("both_req", trap_req, 1'b1);
    trap_ack = 1; tick(); trap_ack = 0;
    check("both_cause_ext", mcause_wr_data, 32'h8000_000B);
    irq_ext = 0;
    tick(); tick(); tick();
    check("both_idle", trap_req, 1'b0);
    mret_vld = 1; tick(); mret_vld = 0;
    tick(); check("both_tmr_req", trap_req, 1'b1);
    trap_ack = 1; tick(); trap_ack = 0;
    check("both_cause_tmr", mcause_wr_data, 32'h8000_0007);
    tick();

    // Long stall with the source dropping, then reset while requesting
    csr_write(12'h7C0, 32'hFFFF_FFFF);
    csr_write(12'h7C1, 32'hFFFF_FFFF);
    irq_ext = 1;
    tick(); tick();
    mret_vld = 1; tick(); mret_vld = 0;
    wait_req(10);
    for (int i = 0; i < 10; i++) begin
      if (i == 5) irq_ext = 0;
      check("hold_req", trap_req, 1'b1);
      tick();
    end
    trap_ack = 1; tick(); trap_ack = 0;
    check("hold_cause", mcause_wr_data, 32'h8000_000B);
    tick();
    irq_ext = 1;
    mret_vld = 1; tick(); mret_vld = 0;
    wait_req(10);
    rst = 0; #1;
    check("arst_trap_req", trap_req, 1'b0);
    check("arst_mepc_vld", mepc_wr_vld, 1'b0);
    check("arst_mcause", mcause_wr_data, 32'h0);
    trap_ack = 1; tick(); tick(); trap_ack = 0;
    rst = 1; irq_ext = 0;
    tick(); check("arst_no_jump", jump_vld, 1'b0);

    // Randomized traffic
    for (int c = 0; c < 800; c++) begin
      logic [11:0] addrs [6];
      addrs[0] = 12'h300; addrs[1] = 12'h304; addrs[2] = 12'h344;
      addrs[3] = 12'h7C0; addrs[4] = 12'h7C1; addrs[5] = 12'h123;
      if ($urandom_range(0, 7) == 0) irq_ext = ~irq_ext;
      if ($urandom_range(0, 15) == 0) mtime = {32'($urandom_range(0, 2)), $urandom};
      else mtime = mtime + 64'd1;
      csr_wr_vld  = ($urandom_range(0, 3) == 0);
      csr_wr_addr = addrs[$urandom_range(0, 5)];
      csr_wr_data = (csr_wr_addr == 12'h7C1) ? 32'($urandom_range(0, 2)) : $urandom;
      csr_rd_addr = addrs[$urandom_range(0, 5)];
      mret_vld    = ($urandom_range(0, 15) == 0);
      trap_ack    = ($urandom_range(0, 2) == 0);
      retire_pc   = $urandom;
      mtvec       = $urandom;
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
